// File: rtl/j1_io_arbiter_pkg.sv
// Shared constants and state type for the j1 I/O arbiter.
package j1_io_arbiter_pkg;

    localparam int unsigned ARB_WIDTH           = 16;
    localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_CPU_BUS  = 2'd1,
        ARB_CPU_ACK  = 2'd2,
        ARB_HOST_BUS = 2'd3
    } arb_state_t;

endpackage

// File: rtl/j1_io_arbiter_rr.sv
// Two-requester round-robin picker. Requester 1 counts as "granted last"
// out of reset, so requester 0 wins the first tie.
module j1_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last;

    // On a tie grant whoever was not served last; otherwise pass the sole request.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    // Remember which requester took the most recent grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/j1_io_arbiter.sv
// Shares one valid/ready peripheral bus between the j1 core I/O port and a
// host/debug port, stalling the core until its access completes.
module j1_io_arbiter
    import j1_io_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = ARB_WIDTH,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_we,
    input  logic             cpu_re,
    input  logic [WIDTH-1:0] cpu_ptr,
    input  logic [WIDTH-1:0] cpu_out,
    output logic [WIDTH-1:0] cpu_in,
    output logic             cpu_stall,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [WIDTH-1:0] host_addr,
    input  logic [WIDTH-1:0] host_wdata,
    output logic             host_gnt,
    output logic             host_done,
    output logic [WIDTH-1:0] host_rdata,
    output logic             bus_valid,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [WIDTH-1:0] bus_wdata,
    input  logic             bus_ready,
    input  logic [WIDTH-1:0] bus_rdata,
    output logic             timeout_err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t       state;
    arb_state_t       state_next;
    logic             cpu_req;
    logic [1:0]       grant;
    logic             advance;
    logic             bus_busy;
    logic             timeout_hit;
    logic             finish;
    logic             abort;
    logic [CW-1:0]    wait_cnt;
    logic [WIDTH-1:0] done_data;

    assign cpu_req  = cpu_we | cpu_re;
    assign advance  = (state == ARB_IDLE) & ~rst;
    assign bus_busy = (state == ARB_CPU_BUS) | (state == ARB_HOST_BUS);

    // Bit 0 = core, bit 1 = host.
    j1_rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({host_req, cpu_req}),
        .advance (advance),
        .grant   (grant)
    );

    // A ready in the same cycle the wait count reaches TIMEOUT wins over the abort.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));
    assign finish      = bus_busy & bus_ready;
    assign abort       = bus_busy & ~bus_ready & timeout_hit;
    assign done_data   = abort ? '1 : bus_rdata;

    assign bus_valid = bus_busy;
    assign cpu_stall = cpu_req & (state != ARB_CPU_ACK) & ~rst;

    // Next-state selection and the combinational host grant pulse.
    always_comb begin
        state_next = state;
        host_gnt   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (!rst) begin
                    if (grant[0]) begin
                        state_next = ARB_CPU_BUS;
                    end else if (grant[1]) begin
                        state_next = ARB_HOST_BUS;
                        host_gnt   = 1'b1;
                    end
                end
            end
            ARB_CPU_BUS: begin
                if (finish | abort) state_next = ARB_CPU_ACK;
            end
            ARB_HOST_BUS: begin
                if (finish | abort) state_next = ARB_IDLE;
            end
            ARB_CPU_ACK: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // State, latched bus fields, wait counter and completion results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            cpu_in      <= '0;
            host_rdata  <= '0;
            host_done   <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state     <= state_next;
            host_done <= 1'b0;
            if (state == ARB_IDLE) begin
                if (grant[0]) begin
                    bus_we    <= cpu_we;
                    bus_addr  <= cpu_ptr;
                    bus_wdata <= cpu_out;
                end else if (grant[1]) begin
                    bus_we    <= host_we;
                    bus_addr  <= host_addr;
                    bus_wdata <= host_wdata;
                end
            end
            if (bus_busy && !(finish || abort)) begin
                wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (finish || abort) begin
                if ((state == ARB_CPU_BUS) && !bus_we) begin
                    cpu_in <= done_data;
                end
                if (state == ARB_HOST_BUS) begin
                    host_rdata <= done_data;
                    host_done  <= 1'b1;
                end
                if (abort) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_j1_io_arbiter.sv
// Self-checking bench for j1_io_arbiter with a randomized bus responder and
// a transaction-level reference model of arbitration order and latency.
module tb_j1_io_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we, cpu_re;
    logic [15:0] cpu_ptr, cpu_out, cpu_in;
    logic        cpu_stall;
    logic        host_req, host_we;
    logic [15:0] host_addr, host_wdata, host_rdata;
    logic        host_gnt, host_done;
    logic        bus_valid, bus_we;
    logic [15:0] bus_addr, bus_wdata;
    logic        bus_ready = 1'b0;
    logic [15:0] bus_rdata = 16'h0;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          vcycles;
        bit          readied;
        bit          stable;
    } txn_t;

    txn_t        log_q[$];
    int          delay_q[$];
    logic [15:0] data_q[$];
    txn_t        cur;
    bit          in_txn = 1'b0;
    int          cur_delay = 0;

    j1_io_arbiter #(.WIDTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_ptr(cpu_ptr), .cpu_out(cpu_out),
        .cpu_in(cpu_in), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_done(host_done),
        .host_rdata(host_rdata),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Peripheral responder: ready after a queued number of wait cycles (-1 = never),
    // logs each bus transaction once bus_valid falls.
    always @(negedge clk) begin
        if (bus_valid) begin
            if (!in_txn) begin
                in_txn      = 1'b1;
                cur.we      = bus_we;
                cur.addr    = bus_addr;
                cur.wdata   = bus_wdata;
                cur.vcycles = 0;
                cur.stable  = 1'b1;
                cur.readied = 1'b0;
                cur.rdata   = (data_q.size() > 0) ? data_q.pop_front() : 16'($urandom);
                cur_delay   = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
            end else if (bus_we !== cur.we || bus_addr !== cur.addr || bus_wdata !== cur.wdata) begin
                cur.stable = 1'b0;
            end
            cur.vcycles++;
            if (cur_delay >= 0 && cur.vcycles == cur_delay + 1) begin
                bus_ready   = 1'b1;
                bus_rdata   = cur.rdata;
                cur.readied = 1'b1;
            end else begin
                bus_ready = 1'b0;
                bus_rdata = 16'($urandom);
            end
        end else begin
            if (in_txn) begin
                log_q.push_back(cur);
                in_txn = 1'b0;
            end
            bus_ready = 1'b0;
            bus_rdata = 16'($urandom);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; host_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        log_q.delete(); delay_q.delete(); data_q.delete();
    endtask

    // Core access held until the ack cycle; returns stall cycle count and cpu_in at ack.
    task automatic cpu_access(input logic we, input logic [15:0] ptr, input logic [15:0] wd,
                              output int stalls, output logic [15:0] ack_in);
        bit acked;
        stalls = 0; ack_in = 'x; acked = 1'b0;
        cpu_we = we; cpu_re = we ? 1'($urandom) : 1'b1; cpu_ptr = ptr; cpu_out = wd;
        for (int i = 0; i < 400 && !acked; i++) begin
            #1;
            if (cpu_stall) begin
                stalls++;
                @(negedge clk);
            end else begin
                ack_in = cpu_in;
                acked  = 1'b1;
            end
        end
        if (acked) @(negedge clk);
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_ptr = 16'($urandom); cpu_out = 16'($urandom);
    endtask

    // Host request held until host_gnt, then fields scrambled; one extra cycle watched for pulses.
    task automatic host_access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                               output int gnts, output int dones, output logic [15:0] rd);
        bit waiting;
        gnts = 0; dones = 0; rd = 'x; waiting = 1'b1;
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
        for (int i = 0; i < 400 && waiting; i++) begin
            #1;
            if (host_gnt) gnts++;
            if (host_done) begin dones++; rd = host_rdata; waiting = 1'b0; end
            @(negedge clk);
            if (gnts > 0) begin
                host_req = 1'b0; host_we = 1'($urandom);
                host_addr = 16'($urandom); host_wdata = 16'($urandom);
            end
        end
        #1;
        if (host_gnt) gnts++;
        if (host_done) dones++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_we = 1'b0; cpu_re = 1'b1; cpu_ptr = 16'h0; cpu_out = 16'h0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0; host_wdata = 16'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_in_rst: got %b expected 0", cpu_stall); end
        @(negedge clk);
        cpu_re = 1'b0; host_req = 1'b0; rst = 1'b0;
        #1;
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid: got %b expected 0", bus_valid); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_bus_we: got %b expected 0", bus_we); end
        checks++; if (bus_addr !== 16'h0) begin errors++; $display("FAIL reset_bus_addr: got %h expected 0000", bus_addr); end
        checks++; if (bus_wdata !== 16'h0) begin errors++; $display("FAIL reset_bus_wdata: got %h expected 0000", bus_wdata); end
        checks++; if (cpu_in !== 16'h0) begin errors++; $display("FAIL reset_cpu_in: got %h expected 0000", cpu_in); end
        checks++; if (host_rdata !== 16'h0) begin errors++; $display("FAIL reset_host_rdata: got %h expected 0000", host_rdata); end
        checks++; if (host_gnt !== 1'b0 || host_done !== 1'b0) begin errors++; $display("FAIL reset_host_pulses: got gnt=%b done=%b expected 0 0", host_gnt, host_done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall: got %b expected 0", cpu_stall); end
        @(negedge clk);
        log_q.delete();
    endtask

    task automatic test_cpu_read();
        int st; logic [15:0] ain;
        log_q.delete(); delay_q.push_back(0); data_q.push_back(16'hBEEF);
        cpu_access(1'b0, 16'h4010, 16'h0000, st, ain);
        checks++; if (st !== 2) begin errors++; $display("FAIL read_stall_cycles: got %0d expected 2", st); end
        checks++; if (ain !== 16'hBEEF) begin errors++; $display("FAIL read_cpu_in: got %h expected beef", ain); end
        checks++; if (log_q.size() !== 1) begin errors++; $display("FAIL read_bus_txns: got %0d expected 1", log_q.size()); end
        if (log_q.size() >= 1) begin
            checks++; if (log_q[0].addr !== 16'h4010 || log_q[0].we !== 1'b0) begin errors++; $display("FAIL read_bus_fields: got addr=%h we=%b expected 4010 0", log_q[0].addr, log_q[0].we); end
            checks++; if (log_q[0].vcycles !== 1) begin errors++; $display("FAIL read_valid_cycles: got %0d expected 1", log_q[0].vcycles); end
        end
    endtask

    task automatic test_cpu_write();
        int st; logic [15:0] ain;
        log_q.delete(); delay_q.push_back(5);
        cpu_access(1'b1, 16'h8002, 16'h1234, st, ain);
        checks++; if (st !== 7) begin errors++; $display("FAIL write_stall_cycles: got %0d expected 7", st); end
        checks++; if (ain !== 16'hBEEF) begin errors++; $display("FAIL write_cpu_in_kept: got %h expected beef", ain); end
        checks++; if (log_q.size() !== 1) begin errors++; $display("FAIL write_bus_txns: got %0d expected 1", log_q.size()); end
        if (log_q.size() >= 1) begin
            checks++; if (log_q[0].we !== 1'b1 || log_q[0].addr !== 16'h8002 || log_q[0].wdata !== 16'h1234) begin errors++; $display("FAIL write_bus_fields: got we=%b addr=%h wdata=%h expected 1 8002 1234", log_q[0].we, log_q[0].addr, log_q[0].wdata); end
            checks++; if (log_q[0].vcycles !== 6) begin errors++; $display("FAIL write_valid_cycles: got %0d expected 6", log_q[0].vcycles); end
            checks++; if (log_q[0].stable !== 1'b1) begin errors++; $display("FAIL write_bus_stable: got %b expected 1", log_q[0].stable); end
        end
    endtask

    task automatic test_round_robin();
        int gc, dc, acks; bit done_all;
        logic [15:0] hr[$];
        logic [15:0] exp_addr[4];
        exp_addr = '{16'h1000, 16'hA000, 16'h1001, 16'hA001};
        do_reset();
        repeat (4) delay_q.push_back(int'($urandom_range(0, 3)));
        cpu_we = 1'b0; cpu_re = 1'b1; cpu_ptr = 16'h1000;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'hA000; host_wdata = 16'h0;
        gc = 0; dc = 0; acks = 0; done_all = 1'b0;
        for (int i = 0; i < 300 && !done_all; i++) begin
            #1;
            if (host_gnt) gc++;
            if (host_done) begin dc++; hr.push_back(host_rdata); end
            if (cpu_re && !cpu_stall) acks++;
            @(negedge clk);
            if (gc == 2 && dc == 2 && acks == 2) done_all = 1'b1;
            cpu_ptr = 16'h1000 + 16'(acks);
            if (acks >= 2) cpu_re = 1'b0;
            host_addr = 16'hA000 + 16'(gc);
            if (gc >= 2) host_req = 1'b0;
        end
        cpu_re = 1'b0; host_req = 1'b0;
        repeat (3) begin
            #1;
            if (host_gnt) gc++;
            if (host_done) dc++;
            @(negedge clk);
        end
        checks++; if (done_all !== 1'b1) begin errors++; $display("FAIL rr_complete: got %b expected 1 (acks=%0d gnt=%0d done=%0d)", done_all, acks, gc, dc); end
        checks++; if (gc !== 2 || dc !== 2) begin errors++; $display("FAIL rr_host_pulses: got gnt=%0d done=%0d expected 2 2", gc, dc); end
        checks++; if (log_q.size() !== 4) begin errors++; $display("FAIL rr_bus_txns: got %0d expected 4", log_q.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < log_q.size()) begin
                checks++; if (log_q[k].addr !== exp_addr[k]) begin errors++; $display("FAIL rr_order_%0d: got %h expected %h", k, log_q[k].addr, exp_addr[k]); end
            end
        end
        if (log_q.size() == 4 && hr.size() == 2) begin
            checks++; if (hr[0] !== log_q[1].rdata || hr[1] !== log_q[3].rdata) begin errors++; $display("FAIL rr_host_rdata: got %h %h expected %h %h", hr[0], hr[1], log_q[1].rdata, log_q[3].rdata); end
        end
    endtask

    task automatic test_random();
        int kind, cd, hd, st, g, dn, ci, hi, exp_st;
        logic cwe, hwe;
        logic [15:0] cptr, cout, haddr, hwd, ain, hrd, model_cpu_in, exp_in;
        bit last_host, cpu_first;
        do_reset();
        last_host = 1'b1; model_cpu_in = 16'h0;
        for (int r = 0; r < 30; r++) begin
            kind = int'($urandom_range(0, 2));
            cd = int'($urandom_range(0, 6)); hd = int'($urandom_range(0, 6));
            cwe = 1'($urandom); hwe = 1'($urandom);
            cptr = {1'b0, 15'($urandom)}; cout = 16'($urandom);
            haddr = {1'b1, 15'($urandom)}; hwd = 16'($urandom);
            log_q.delete();
            if (kind == 0) begin
                delay_q.push_back(cd);
                cpu_access(cwe, cptr, cout, st, ain);
                checks++; if (st !== cd + 2) begin errors++; $display("FAIL rand%0d_cpu_stall: got %0d expected %0d", r, st, cd + 2); end
                checks++; if (log_q.size() !== 1) begin errors++; $display("FAIL rand%0d_cpu_txns: got %0d expected 1", r, log_q.size()); end
                if (log_q.size() == 1) begin
                    exp_in = cwe ? model_cpu_in : log_q[0].rdata;
                    checks++; if (log_q[0].addr !== cptr || log_q[0].we !== cwe || (cwe && log_q[0].wdata !== cout)) begin errors++; $display("FAIL rand%0d_cpu_bus: got addr=%h we=%b expected %h %b", r, log_q[0].addr, log_q[0].we, cptr, cwe); end
                    checks++; if (ain !== exp_in) begin errors++; $display("FAIL rand%0d_cpu_in: got %h expected %h", r, ain, exp_in); end
                    model_cpu_in = exp_in;
                end
                last_host = 1'b0;
            end else if (kind == 1) begin
                delay_q.push_back(hd);
                host_access(hwe, haddr, hwd, g, dn, hrd);
                checks++; if (g !== 1 || dn !== 1) begin errors++; $display("FAIL rand%0d_host_pulses: got gnt=%0d done=%0d expected 1 1", r, g, dn); end
                checks++; if (log_q.size() !== 1) begin errors++; $display("FAIL rand%0d_host_txns: got %0d expected 1", r, log_q.size()); end
                if (log_q.size() == 1) begin
                    checks++; if (log_q[0].addr !== haddr || log_q[0].we !== hwe) begin errors++; $display("FAIL rand%0d_host_bus: got addr=%h we=%b expected %h %b", r, log_q[0].addr, log_q[0].we, haddr, hwe); end
                    checks++; if (hrd !== log_q[0].rdata) begin errors++; $display("FAIL rand%0d_host_rdata: got %h expected %h", r, hrd, log_q[0].rdata); end
                end
                last_host = 1'b1;
            end else begin
                cpu_first = last_host;
                if (cpu_first) begin delay_q.push_back(cd); delay_q.push_back(hd); end
                else begin delay_q.push_back(hd); delay_q.push_back(cd); end
                fork
                    begin cpu_access(cwe, cptr, cout, st, ain); end
                    begin host_access(hwe, haddr, hwd, g, dn, hrd); end
                join
                exp_st = cpu_first ? cd + 2 : cd + hd + 4;
                ci = cpu_first ? 0 : 1; hi = 1 - ci;
                checks++; if (st !== exp_st) begin errors++; $display("FAIL rand%0d_tie_stall: got %0d expected %0d", r, st, exp_st); end
                checks++; if (g !== 1 || dn !== 1) begin errors++; $display("FAIL rand%0d_tie_pulses: got gnt=%0d done=%0d expected 1 1", r, g, dn); end
                checks++; if (log_q.size() !== 2) begin errors++; $display("FAIL rand%0d_tie_txns: got %0d expected 2", r, log_q.size()); end
                if (log_q.size() == 2) begin
                    exp_in = cwe ? model_cpu_in : log_q[ci].rdata;
                    checks++; if (log_q[ci].addr !== cptr || log_q[hi].addr !== haddr) begin errors++; $display("FAIL rand%0d_tie_order: got %h,%h expected cpu %h at %0d host %h", r, log_q[0].addr, log_q[1].addr, cptr, ci, haddr); end
                    checks++; if (ain !== exp_in) begin errors++; $display("FAIL rand%0d_tie_cpu_in: got %h expected %h", r, ain, exp_in); end
                    checks++; if (hrd !== log_q[hi].rdata) begin errors++; $display("FAIL rand%0d_tie_host_rdata: got %h expected %h", r, hrd, log_q[hi].rdata); end
                    model_cpu_in = exp_in;
                end
                last_host = cpu_first;
            end
        end
    endtask

    task automatic test_timeout_boundary();
        int st; logic [15:0] ain;
        log_q.delete(); delay_q.push_back(7); data_q.push_back(16'h5A5A);
        cpu_access(1'b0, 16'h0123, 16'h0, st, ain);
        checks++; if (st !== 9) begin errors++; $display("FAIL tboundary_stall: got %0d expected 9", st); end
        checks++; if (ain !== 16'h5A5A) begin errors++; $display("FAIL tboundary_cpu_in: got %h expected 5a5a", ain); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tboundary_err: got %b expected 0", timeout_err); end
        if (log_q.size() == 1) begin
            checks++; if (log_q[0].vcycles !== 8) begin errors++; $display("FAIL tboundary_valid_cycles: got %0d expected 8", log_q[0].vcycles); end
        end
    endtask

    task automatic test_timeout();
        int st, g, dn; logic [15:0] ain, hrd;
        log_q.delete(); delay_q.push_back(-1);
        cpu_access(1'b0, 16'h0456, 16'h0, st, ain);
        checks++; if (st !== 9) begin errors++; $display("FAIL timeout_stall: got %0d expected 9", st); end
        checks++; if (ain !== 16'hFFFF) begin errors++; $display("FAIL timeout_cpu_in: got %h expected ffff", ain); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set: got %b expected 1", timeout_err); end
        checks++; if (log_q.size() !== 1) begin errors++; $display("FAIL timeout_txns: got %0d expected 1", log_q.size()); end
        if (log_q.size() == 1) begin
            checks++; if (log_q[0].vcycles !== 8) begin errors++; $display("FAIL timeout_valid_cycles: got %0d expected 8", log_q[0].vcycles); end
        end
        log_q.delete(); delay_q.push_back(2);
        host_access(1'b0, 16'hC000, 16'h0, g, dn, hrd);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky: got %b expected 1", timeout_err); end
        if (log_q.size() == 1) begin
            checks++; if (hrd !== log_q[0].rdata) begin errors++; $display("FAIL timeout_after_host_rdata: got %h expected %h", hrd, log_q[0].rdata); end
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int st, extra; logic [15:0] ain;
        log_q.delete(); delay_q.push_back(1);
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'hD00D; host_wdata = 16'h0;
        #1;
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt: got %b expected 1", host_gnt); end
        @(negedge clk);
        host_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL midrst_bus_valid: got %b expected 0", bus_valid); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL midrst_timeout_err: got %b expected 0", timeout_err); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL midrst_cpu_stall: got %b expected 0", cpu_stall); end
        checks++; if (host_rdata !== 16'h0) begin errors++; $display("FAIL midrst_host_rdata: got %h expected 0000", host_rdata); end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (host_done) extra++;
            @(negedge clk);
            #1;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", extra); end
        @(negedge clk);
        log_q.delete(); delay_q.delete(); data_q.delete();
        delay_q.push_back(0);
        cpu_access(1'b0, 16'h0777, 16'h0, st, ain);
        checks++; if (st !== 2) begin errors++; $display("FAIL midrst_idle_after: got stall %0d expected 2", st); end
        if (log_q.size() == 1) begin
            checks++; if (ain !== log_q[0].rdata) begin errors++; $display("FAIL midrst_cpu_in: got %h expected %h", ain, log_q[0].rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_round_robin();
        test_random();
        test_timeout_boundary();
        test_timeout();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
